// File: rtl/cic_decim_ctrl_if.sv
// Host-configuration and CIC-side signal bundle for cic_decim_ctrl.
// master = host/CIC side, slave = the sequencer itself.
interface cic_decim_ctrl_if #(
  parameter int MD = 14
);
  logic          cfg_wr;
  logic [3:0]    cfg_log2;
  logic          cfg_busy;
  logic          cfg_err;
  logic          cic_reset;
  logic [MD-1:0] cic_decimation;
  logic          cic_out_strobe;
  logic          out_strobe;
  logic          out_valid;

  modport master (
    output cfg_wr, cfg_log2, cic_out_strobe,
    input  cfg_busy, cfg_err, cic_reset, cic_decimation, out_strobe, out_valid
  );

  modport slave (
    input  cfg_wr, cfg_log2, cic_out_strobe,
    output cfg_busy, cfg_err, cic_reset, cic_decimation, out_strobe, out_valid
  );
endinterface

// File: rtl/cic_decim_ctrl.sv
// Reconfiguration sequencer for a 2**n CIC decimator: hold in reset, flush settling
// outputs, then run. Optional drop counter enabled by defining CIC_CTRL_DROP_CNT_EN.
module cic_decim_ctrl #(
  parameter int STAGES       = 5,
  parameter int MAX_LOG2     = 11,
  parameter int MD           = 14,
  parameter int RST_CYCLES   = 4,
  parameter int DEFAULT_LOG2 = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  cic_decim_ctrl_if.slave      bus
`ifdef CIC_CTRL_DROP_CNT_EN
  ,
  output logic [15:0]          drop_cnt
`endif
);

  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam int FW = $clog2(STAGES + 2);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_FLUSH = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [MD-1:0] dec_q, dec_d;
  logic          cfg_err_q, cfg_err_d;
  logic          log2_legal;
  logic          legal_wr;

  assign log2_legal = ({28'd0, bus.cfg_log2} <= 32'(MAX_LOG2));
  assign legal_wr   = bus.cfg_wr && log2_legal;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    flush_cnt_d = flush_cnt_q;
    dec_d       = dec_q;
    cfg_err_d   = bus.cfg_wr && !log2_legal;

    if (legal_wr) begin
      // A legal write always restarts the whole sequence, even mid-sequence.
      state_d     = S_HOLD;
      hold_cnt_d  = HW'(RST_CYCLES - 1);
      flush_cnt_d = '0;
      dec_d       = MD'(1) << bus.cfg_log2;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (hold_cnt_q == '0) begin
            state_d     = S_FLUSH;
            flush_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q - 1'b1;
          end
        end
        S_FLUSH: begin
          if (bus.cic_out_strobe) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
            if (flush_cnt_q == FW'(STAGES)) state_d = S_RUN;
          end
        end
        S_RUN:   state_d = S_RUN;
        default: state_d = S_HOLD;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_HOLD;
      hold_cnt_q  <= HW'(RST_CYCLES - 1);
      flush_cnt_q <= '0;
      dec_q       <= MD'(1) << DEFAULT_LOG2;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      dec_q       <= dec_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bus.cic_reset      = (state_q == S_HOLD);
  assign bus.cfg_busy       = (state_q != S_RUN);
  assign bus.out_valid      = (state_q == S_RUN);
  assign bus.out_strobe     = bus.cic_out_strobe && (state_q == S_RUN);
  assign bus.cfg_err        = cfg_err_q;
  assign bus.cic_decimation = dec_q;

`ifdef CIC_CTRL_DROP_CNT_EN
  // Strobes swallowed while flushing, regardless of a coincident cfg_wr.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (state_q == S_FLUSH && bus.cic_out_strobe && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl; forwarded strobes and cfg_err pulses are
// checked by a negedge monitor against a queue of expected events.
module tb_cic_decim_ctrl;

  logic clock;
  logic reset_n;

  cic_decim_ctrl_if #(.MD(14)) bus ();

`ifdef CIC_CTRL_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  cic_decim_ctrl #(
    .STAGES(5), .MAX_LOG2(11), .MD(14), .RST_CYCLES(4), .DEFAULT_LOG2(0)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef CIC_CTRL_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          is_err;
    logic [13:0] dec;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  logic [13:0] exp_dec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every visible output event must match the head of the queue.
  always @(negedge clock) begin
    if (bus.out_strobe || bus.cfg_err) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", {30'd0, bus.out_strobe, bus.cfg_err}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("event_kind_err", {31'd0, bus.cfg_err}, {31'd0, mon_e.is_err});
        check("event_kind_stb", {31'd0, bus.out_strobe}, {31'd0, !mon_e.is_err});
        check("event_decimation", {18'd0, bus.cic_decimation}, {18'd0, mon_e.dec});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic stb, input logic wr, input logic [3:0] l2);
    bus.cic_out_strobe = stb;
    bus.cfg_wr         = wr;
    bus.cfg_log2       = l2;
    tick();
    bus.cic_out_strobe = 1'b0;
    bus.cfg_wr         = 1'b0;
  endtask

  task automatic strobe(input bit fwd);
    if (fwd) sb_q.push_back('{is_err: 1'b0, dec: exp_dec});
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
  endtask

  task automatic expect_hold(input string name);
    int n;
    n = 0;
    while (bus.cic_reset && n < 20) begin
      n++;
      tick();
    end
    check(name, n, 32'd4);
  endtask

  task automatic flush6(input string name);
    for (int i = 0; i < 5; i++) strobe(1'b0);
    check({name, "_valid_early"}, {31'd0, bus.out_valid}, 32'd0);
    strobe(1'b0);
    check({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({name, "_busy"}, {31'd0, bus.cfg_busy}, 32'd0);
  endtask

  task automatic legal_write(input logic [3:0] l2, input string name);
    step(1'b0, 1'b1, l2);
    exp_dec = 14'd1 << l2;
    check({name, "_dec"}, {18'd0, bus.cic_decimation}, {18'd0, exp_dec});
    check({name, "_busy"}, {31'd0, bus.cfg_busy}, 32'd1);
  endtask

  initial begin
    reset_n            = 1'b0;
    bus.cfg_wr         = 1'b0;
    bus.cfg_log2       = 4'd0;
    bus.cic_out_strobe = 1'b0;
    exp_dec            = 14'd1;
    repeat (3) tick();

    // Reset state, then power-up sequence with DEFAULT_LOG2=0.
    check("rst_cic_reset", {31'd0, bus.cic_reset}, 32'd1);
    check("rst_busy", {31'd0, bus.cfg_busy}, 32'd1);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_err", {31'd0, bus.cfg_err}, 32'd0);
    check("rst_dec", {18'd0, bus.cic_decimation}, 32'd1);
    reset_n = 1'b1;
    expect_hold("pwr_hold");
    flush6("pwr_flush");
    for (int i = 0; i < 3; i++) strobe(1'b1);

    // cfg_wr log2=5 coincident with a strobe in RUN: that strobe still forwarded.
    sb_q.push_back('{is_err: 1'b0, dec: exp_dec});
    step(1'b1, 1'b1, 4'd5);
    exp_dec = 14'd32;
    check("r32_dec", {18'd0, bus.cic_decimation}, 32'd32);
    check("r32_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    expect_hold("r32_hold");
    flush6("r32_flush");
    for (int i = 0; i < 2; i++) strobe(1'b1);

    // Illegal log2=12: one-clock cfg_err, nothing else moves.
    sb_q.push_back('{is_err: 1'b1, dec: exp_dec});
    step(1'b0, 1'b1, 4'd12);
    check("ill_err_pulse", {31'd0, bus.cfg_err}, 32'd1);
    tick();
    check("ill_err_clear", {31'd0, bus.cfg_err}, 32'd0);
    check("ill_dec", {18'd0, bus.cic_decimation}, 32'd32);
    check("ill_valid", {31'd0, bus.out_valid}, 32'd1);

    // Mid-FLUSH write, then mid-HOLD write: both counters restart.
    legal_write(4'd4, "r16");
    expect_hold("r16_hold");
    for (int i = 0; i < 3; i++) strobe(1'b0);
    legal_write(4'd3, "r8");
    tick();
    tick();
    legal_write(4'd7, "r128");
    expect_hold("r128_hold");
    flush6("r128_flush");
    strobe(1'b1);

    // Asynchronous reset mid-FLUSH at R=256.
    legal_write(4'd8, "r256");
    expect_hold("r256_hold");
    strobe(1'b0);
    strobe(1'b0);
    reset_n = 1'b0;
    #1;
    check("async_cic_reset", {31'd0, bus.cic_reset}, 32'd1);
    check("async_dec", {18'd0, bus.cic_decimation}, 32'd1);
    check("async_busy", {31'd0, bus.cfg_busy}, 32'd1);
    #2;
    reset_n = 1'b1;
    exp_dec = 14'd1;
    expect_hold("rerst_hold");
    flush6("rerst_flush");
    strobe(1'b1);

    // Two more full sequences after reset: 18 strobes discarded in total.
    legal_write(4'd2, "r4");
    expect_hold("r4_hold");
    flush6("r4_flush");
    legal_write(4'd1, "r2");
    expect_hold("r2_hold");
    flush6("r2_flush");
    strobe(1'b1);
`ifdef CIC_CTRL_DROP_CNT_EN
    check("drop_cnt", {16'd0, drop_cnt}, 32'd18);
`endif

    tick();
    check("queue_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
